// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds one DIGIT-bit slice per clock, LSB first,
// with the inter-slice carry held in a flop. Results are held until the next completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT >= 1");
    end

    // Handshake: start is accepted on any rising edge where busy=0; done pulses
    // for one cycle when sum/cout/ovf have just been updated.
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice;
    logic             c_msb;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        slice    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // Carry into the top bit of this slice; only meaningful on the last slice.
        c_msb    = slice[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
        acc_next = (acc >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= acc_next;
                    carry <= slice[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        sum   <= acc_next;
                        cout  <= slice[DIGIT];
                        ovf   <= c_msb ^ slice[DIGIT];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
